// File: rtl/fir_gen_param_if.sv
// Sample/coefficient input and scaled-output bundle for fir_gen_param.
interface fir_gen_param_if #(
  parameter int W1 = 8,
  parameter int WC = 8,
  parameter int W4 = 8
);
  logic                 load_en;
  logic                 c_valid;
  logic signed [WC-1:0] c_in;
  logic                 x_valid;
  logic signed [W1-1:0] x_in;
  logic signed [W4-1:0] y_out;
  logic                 y_valid;
  logic                 sat;
  logic                 coef_ok;

  modport master (
    output load_en, c_valid, c_in, x_valid, x_in,
    input  y_out, y_valid, sat, coef_ok
  );

  modport slave (
    input  load_en, c_valid, c_in, x_valid, x_in,
    output y_out, y_valid, sat, coef_ok
  );
endinterface

// File: rtl/fir_gen_param.sv
// L-tap transposed FIR with run-time coefficient loading (IDLE/LOAD/RUN),
// per-sample valid handshake, round-half-up scaling and output saturation.
module fir_gen_param #(
  parameter int W1    = 8,
  parameter int WC    = 8,
  parameter int L     = 8,
  parameter int WA    = W1 + WC + $clog2(L),
  parameter int W4    = 8,
  parameter int SHIFT = WA - W4,
  parameter int ROUND = 1
) (
  input logic            clk,
  input logic            reset_n,
  fir_gen_param_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam int CW = $clog2(L + 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(L);
  localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [WA:0] RND_ADD = (ROUND != 0 && SHIFT > 0) ?
      ({{WA{1'b0}}, 1'b1} << SHIFT_M1) : {(WA+1){1'b0}};
  localparam logic signed [WA:0] Y_MAX = {{(WA+2-W4){1'b0}}, {(W4-1){1'b1}}};
  localparam logic signed [WA:0] Y_MIN = {{(WA+2-W4){1'b1}}, {(W4-1){1'b0}}};

  logic [1:0]           state_r;
  logic [CW-1:0]        count_r;
  logic signed [WC-1:0] coef_r [L];
  logic signed [WA-1:0] acc_r [L];
  logic signed [WA-1:0] acc_next_s [L];
  logic signed [WA-1:0] x_ext_s;
  logic signed [WA:0]   rnd_s;
  logic signed [WA:0]   shifted_s;
  logic signed [W4-1:0] y_s;
  logic                 sat_s;
  logic signed [W4-1:0] y_r;
  logic                 y_valid_r;
  logic                 sat_r;

  // Tap update for an accepted sample, then round, shift and clamp the new a[0].
  always_comb begin
    x_ext_s = {{(WA-W1){bus.x_in[W1-1]}}, bus.x_in};
    for (int k = 0; k < L - 1; k++) begin
      acc_next_s[k] = x_ext_s * $signed({{(WA-WC){coef_r[k][WC-1]}}, coef_r[k]}) + acc_r[k+1];
    end
    acc_next_s[L-1] = x_ext_s * $signed({{(WA-WC){coef_r[L-1][WC-1]}}, coef_r[L-1]});
    rnd_s     = $signed({acc_next_s[0][WA-1], acc_next_s[0]}) + RND_ADD;
    shifted_s = rnd_s >>> SHIFT;
    if (shifted_s > Y_MAX) begin
      y_s   = Y_MAX[W4-1:0];
      sat_s = 1'b1;
    end else if (shifted_s < Y_MIN) begin
      y_s   = Y_MIN[W4-1:0];
      sat_s = 1'b1;
    end else begin
      y_s   = shifted_s[W4-1:0];
      sat_s = 1'b0;
    end
  end

  // Load/run control, coefficient shift register, tap registers and output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      count_r   <= {CW{1'b0}};
      for (int k = 0; k < L; k++) begin
        coef_r[k] <= {WC{1'b0}};
        acc_r[k]  <= {WA{1'b0}};
      end
      y_r       <= {W4{1'b0}};
      y_valid_r <= 1'b0;
      sat_r     <= 1'b0;
    end else begin
      y_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.load_en) begin
            state_r <= ST_LOAD;
            count_r <= {CW{1'b0}};
          end
        end
        ST_LOAD: begin
          // Keeps shifting past L so the most recent L coefficients win.
          if (bus.c_valid) begin
            for (int k = 0; k < L - 1; k++) begin
              coef_r[k] <= coef_r[k+1];
            end
            coef_r[L-1] <= bus.c_in;
            if (count_r != COUNT_FULL) begin
              count_r <= count_r + CW'(1);
            end
          end
          if (!bus.load_en) begin
            state_r <= (count_r == COUNT_FULL) ? ST_RUN : ST_IDLE;
          end
        end
        ST_RUN: begin
          if (bus.load_en) begin
            state_r <= ST_LOAD;
            count_r <= {CW{1'b0}};
            for (int k = 0; k < L; k++) begin
              acc_r[k] <= {WA{1'b0}};
            end
          end else if (bus.x_valid) begin
            acc_r     <= acc_next_s;
            y_r       <= y_s;
            sat_r     <= sat_s;
            y_valid_r <= 1'b1;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.y_out   = y_r;
  assign bus.y_valid = y_valid_r;
  assign bus.sat     = sat_r;
  assign bus.coef_ok = (state_r == ST_RUN);
endmodule
